add_bcd: RTL and testbench

Registered binary-to-BCD adder. Adds two 4-bit unsigned binary operands (each 0..15) and presents the sum (0..30) as two BCD digits: tens (`D`) and units (`U`). Used as a small arithmetic leaf feeding BCD display or decimal-formatting logic. Outputs are registered with one cycle of latency.

---
 rtl/add_bcd.sv | 70 +++++++
 tb/tb_add_bcd.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_bcd.sv
// add_bcd: registered adder of two 4-bit binary operands whose 0..30 sum
// is presented as two BCD digits (tens D, units U) one cycle later.
module add_bcd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] D,
    output logic [3:0] U,
    output logic       out_valid
);

    logic [4:0] sum;
    logic [1:0] tens;
    logic [4:0] units_wide;

    logic [3:0] d_q, d_d;
    logic [3:0] u_q, u_d;
    logic       valid_q, valid_d;

    // Binary sum and compare/subtract digit split (no divider needed for 0..30).
    always_comb begin
        sum = {1'b0, A} + {1'b0, B};
        if (sum >= 5'd30) begin
            tens       = 2'd3;
            units_wide = sum - 5'd30;
        end else if (sum >= 5'd20) begin
            tens       = 2'd2;
            units_wide = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            tens       = 2'd1;
            units_wide = sum - 5'd10;
        end else begin
            tens       = 2'd0;
            units_wide = sum;
        end
    end

    // Next-state: load digits only on a valid beat so don't-care operands
    // never reach the output flops; otherwise hold.
    always_comb begin
        d_d     = d_q;
        u_d     = u_q;
        valid_d = 1'b0;
        if (in_valid) begin
            d_d     = {2'b00, tens};
            u_d     = units_wide[3:0];
            valid_d = 1'b1;
        end
    end

    // Output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= 4'd0;
            u_q     <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            u_q     <= u_d;
            valid_q <= valid_d;
        end
    end

    assign D         = d_q;
    assign U         = u_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_add_bcd.sv
// Self-checking bench for add_bcd: directed, exhaustive and random stimulus
// against a decimal reference model (sum / 10, sum % 10).
module tb_add_bcd;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] D;
    logic [3:0] U;
    logic       out_valid;

    int checks;
    int failures;

    add_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .D         (D),
        .U         (U),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_tens(input int a, input int b);
        return 4'((a + b) / 10);
    endfunction

    function automatic logic [3:0] ref_units(input int a, input int b);
        return 4'((a + b) % 10);
    endfunction

    // Present one valid pair and step to the next negedge where its result is visible.
    task automatic apply_pair(input int a, input int b);
        A        = 4'(a);
        B        = 4'(b);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] ed, eu;
        // Load a non-zero result first so the clear is observable.
        apply_pair(9, 8);
        ed = ref_tens(9, 8);
        eu = ref_units(9, 8);
        checks++;
        if (D !== ed || U !== eu || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL preload D=%0d U=%0d ov=%b expected D=%0d U=%0d ov=1", D, U, out_valid, ed, eu);
        end
        A = 4'd15; B = 4'd15; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (D !== 4'd0 || U !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async D=%0d U=%0d ov=%b expected 0 0 0", D, U, out_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (D !== 4'd0 || U !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_held D=%0d U=%0d ov=%b expected 0 0 0", D, U, out_valid);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (D !== 4'd0 || U !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release D=%0d U=%0d ov=%b expected 0 0 0", D, U, out_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_pairs(input string name, input int n, input int as[8], input int bs[8]);
        logic [3:0] ed, eu;
        for (int i = 0; i < n; i++) begin
            apply_pair(as[i], bs[i]);
            ed = ref_tens(as[i], bs[i]);
            eu = ref_units(as[i], bs[i]);
            checks++;
            if (D !== ed || U !== eu || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s A=%0d B=%0d got D=%0d U=%0d ov=%b expected D=%0d U=%0d ov=1",
                         name, as[i], bs[i], D, U, out_valid, ed, eu);
            end else begin
                $display("%s A=%0d B=%0d -> D=%0d U=%0d", name, as[i], bs[i], D, U);
            end
        end
    endtask

    task automatic test_basic;
        test_pairs("basic", 3, '{2, 9, 10, 0, 0, 0, 0, 0}, '{1, 6, 9, 0, 0, 0, 0, 0});
    endtask

    task automatic test_boundary;
        test_pairs("boundary", 5, '{0, 5, 15, 15, 15, 0, 0, 0}, '{0, 5, 5, 15, 14, 0, 0, 0});
    endtask

    // All 256 pairs back-to-back; each result is checked one cycle after its operands.
    task automatic test_back_to_back;
        int pa, pb;
        int bad;
        bad = 0;
        pa  = -1;
        pb  = -1;
        for (int i = 0; i <= 256; i++) begin
            if (pa >= 0) begin
                checks++;
                if (D !== ref_tens(pa, pb) || U !== ref_units(pa, pb) || out_valid !== 1'b1
                    || (int'(D) * 10 + int'(U)) != pa + pb || U > 4'd9 || D > 4'd3) begin
                    failures++;
                    bad++;
                    $display("FAIL sweep A=%0d B=%0d got D=%0d U=%0d ov=%b expected D=%0d U=%0d ov=1",
                             pa, pb, D, U, out_valid, ref_tens(pa, pb), ref_units(pa, pb));
                end
            end
            if (i < 256) begin
                pa = i / 16;
                pb = i % 16;
                A = 4'(pa);
                B = 4'(pb);
                in_valid = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        $display("sweep 256 pairs, %0d bad", bad);
    endtask

    task automatic test_hold;
        apply_pair(7, 8);
        checks++;
        if (D !== 4'd1 || U !== 4'd5 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_load D=%0d U=%0d ov=%b expected D=1 U=5 ov=1", D, U, out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b0;
            if (i % 2 == 0) begin
                A = 4'bxxxx;
                B = 4'bxxxx;
            end else begin
                A = 4'($urandom_range(15));
                B = 4'($urandom_range(15));
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (D !== 4'd1 || U !== 4'd5 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d D=%0d U=%0d ov=%b expected D=1 U=5 ov=0", i, D, U, out_valid);
            end else begin
                $display("hold cycle %0d D=%0d U=%0d ov=%b", i, D, U, out_valid);
            end
        end
    endtask

    task automatic test_reset_in_flight;
        A = 4'd9; B = 4'd9; in_valid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (D !== 4'd0 || U !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flight_reset D=%0d U=%0d ov=%b expected 0 0 0", D, U, out_valid);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (D !== 4'd0 || U !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flight_after D=%0d U=%0d ov=%b expected 0 0 0", D, U, out_valid);
        end
        apply_pair(3, 4);
        checks++;
        if (D !== 4'd0 || U !== 4'd7 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flight_next D=%0d U=%0d ov=%b expected D=0 U=7 ov=1", D, U, out_valid);
        end else begin
            $display("reset in flight then A=3 B=4 -> D=%0d U=%0d", D, U);
        end
    endtask

    // Random operands with random in_valid; the model holds its last result on idle beats.
    task automatic test_random;
        logic [3:0] ed, eu;
        logic       ev;
        int a, b;
        ed = D;
        eu = U;
        for (int i = 0; i < 200; i++) begin
            a  = int'($urandom_range(15));
            b  = int'($urandom_range(15));
            ev = 1'($urandom_range(1));
            A = 4'(a);
            B = 4'(b);
            in_valid = ev;
            if (ev) begin
                ed = ref_tens(a, b);
                eu = ref_units(a, b);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (D !== ed || U !== eu || out_valid !== ev) begin
                failures++;
                $display("FAIL random%0d A=%0d B=%0d v=%b got D=%0d U=%0d ov=%b expected D=%0d U=%0d ov=%b",
                         i, a, b, ev, D, U, out_valid, ed, eu, ev);
            end
        end
        in_valid = 1'b0;
        $display("random 200 beats done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 4'd0;
        B        = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_boundary;
        test_back_to_back;
        test_hold;
        test_reset_in_flight;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
